// File: rtl/aes_unload_pkg.sv
// Shared types and word-select helper for the AES text_out unloader.
package aes_unload_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORDS  = 4;
  localparam int AES_WORD_W = AES_BLK_W / AES_WORDS;

  typedef logic [AES_BLK_W-1:0]  aes_blk_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;

  typedef enum logic {UL_IDLE, UL_SEND} ul_state_e;

  // idx counts transfer order; msw_first decides which end of the block leaves first.
  function automatic aes_word_t word_sel(input aes_blk_t blk, input logic [1:0] idx,
                                         input bit msw_first);
    logic [1:0] pos;
    pos = msw_first ? 2'd3 - idx : idx;
    return blk[AES_WORD_W*pos +: AES_WORD_W];
  endfunction

endpackage

// File: rtl/aes_blk_buf2.sv
// Two-entry 128-bit block FIFO; a push and pop on the same edge reuse the freed slot.
module aes_blk_buf2
  import aes_unload_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr,
  input  aes_blk_t wdata,
  input  logic     rd_pop,
  output aes_blk_t rdata,
  output aes_blk_t rnext,
  output logic [1:0] occ,
  output logic     full,
  output logic     empty
);

  aes_blk_t mem [2];
  logic     wptr;
  logic     rptr;

  // NOTE: block storage is deliberately not reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  // NOTE: non-blocking assignments keep all state updates on the same edge order-independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (wr)     wptr <= ~wptr;
      if (rd_pop) rptr <= ~rptr;
      case ({wr, rd_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign rnext = mem[~rptr];
  assign full  = (occ == 2'd2);
  assign empty = (occ == 2'd0);

endmodule

// File: rtl/aes_text_out_unloader.sv
// Buffers AES cipher results and streams each as four 32-bit words on a valid/ready port.
// Optional AES_UNLOAD_DROPCNT_EN adds a saturating dropped-block counter drop_cnt.
module aes_text_out_unloader
  import aes_unload_pkg::*;
#(
  parameter bit MSW_FIRST = 1'b1,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic [127:0]  text_out,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          overrun,
`ifdef AES_UNLOAD_DROPCNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic          busy
);

  ul_state_e  state;
  logic [1:0] wcnt;
  aes_blk_t   rdata;
  aes_blk_t   rnext;
  aes_blk_t   nxt_blk;
  logic [1:0] occ;
  logic       full;
  logic       empty;
  logic       hs;
  logic       last_hs;
  logic       wr;
  logic       drop;
  logic       has_next;

  assign hs      = m_valid && m_ready;
  assign last_hs = hs && (wcnt == 2'd3);
  // A full buffer still accepts when the block in flight completes on this edge.
  assign wr      = done && (!full || last_hs);
  assign drop    = done && full && !last_hs;
  assign busy    = !empty;

  // After a final handshake the next block is either already queued or arriving right now.
  assign has_next = (occ == 2'd2) || wr;
  assign nxt_blk  = (occ == 2'd2) ? rnext : text_out;

  aes_blk_buf2 u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .wdata (text_out),
    .rd_pop(last_hs),
    .rdata (rdata),
    .rnext (rnext),
    .occ   (occ),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= UL_IDLE;
      wcnt    <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        UL_IDLE: begin
          if (!empty) begin
            state   <= UL_SEND;
            wcnt    <= 2'd0;
            m_valid <= 1'b1;
            m_data  <= word_sel(rdata, 2'd0, MSW_FIRST);
            m_last  <= 1'b0;
          end
        end
        UL_SEND: begin
          if (hs) begin
            if (wcnt != 2'd3) begin
              wcnt   <= wcnt + 2'd1;
              m_data <= word_sel(rdata, wcnt + 2'd1, MSW_FIRST);
              m_last <= (wcnt == 2'd2);
            end else if (has_next) begin
              wcnt   <= 2'd0;
              m_data <= word_sel(nxt_blk, 2'd0, MSW_FIRST);
              m_last <= 1'b0;
            end else begin
              state   <= UL_IDLE;
              wcnt    <= 2'd0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
          end
        end
        default: state <= UL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun  <= 1'b0;
`ifdef AES_UNLOAD_DROPCNT_EN
      drop_cnt <= 8'd0;
`endif
    end else if (drop) begin
      overrun  <= 1'b1;
`ifdef AES_UNLOAD_DROPCNT_EN
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_aes_text_out_unloader.sv
// Self-checking bench: directed scenarios plus a word-queue reference model for both word orders.
module tb_aes_text_out_unloader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done = 1'b0;
  logic         m_ready = 1'b0;
  logic [127:0] text_out = '0;

  logic         m_valid, m_last, overrun, busy;
  logic [31:0]  m_data;
  logic         v1, l1, o1, b1;
  logic [31:0]  d1;
`ifdef AES_UNLOAD_DROPCNT_EN
  logic [7:0]   drop_cnt, dc1;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  aes_text_out_unloader #(.MSW_FIRST(1'b1), .DW(32)) dut (
    .clk(clk), .rst(rst), .done(done), .text_out(text_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .overrun(overrun),
`ifdef AES_UNLOAD_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .busy(busy)
  );

  aes_text_out_unloader #(.MSW_FIRST(1'b0), .DW(32)) dut_lsw (
    .clk(clk), .rst(rst), .done(done), .text_out(text_out),
    .m_valid(v1), .m_data(d1), .m_last(l1), .m_ready(m_ready),
    .overrun(o1),
`ifdef AES_UNLOAD_DROPCNT_EN
    .drop_cnt(dc1),
`endif
    .busy(b1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wd(input logic [127:0] b, input int k, input bit msw);
    logic [127:0] s;
    s = msw ? (b >> (32 * (3 - k))) : (b >> (32 * k));
    return s[31:0];
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: a queue of expected words per order; a block occupies the buffer until its last word goes.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          exp_ovr = 1'b0;
  bit          start_wait = 1'b0;
  int          exp_drop = 0;

  always @(negedge clk) begin : model
    bit ev, hs, last;
    int pend;
    if (rst) begin
      q0.delete(); q1.delete();
      exp_ovr = 1'b0; exp_drop = 0; start_wait = 1'b0;
    end else begin
      ev = (q0.size() != 0) && !start_wait;
      checks++;
      if (m_valid !== ev || v1 !== ev) begin
        errors++;
        $display("FAIL mon_valid t=%0t: got %b/%b expected %b", $time, m_valid, v1, ev);
      end
      if (ev) begin
        checks++;
        if (m_data !== q0[0] || d1 !== q1[0] ||
            m_last !== (q0.size() % 4 == 1) || l1 !== (q0.size() % 4 == 1)) begin
          errors++;
          $display("FAIL mon_word t=%0t: got %h/%h last %b/%b expected %h/%h last %b", $time,
                   m_data, d1, m_last, l1, q0[0], q1[0], (q0.size() % 4 == 1));
        end
      end
      checks++;
      if (overrun !== exp_ovr || o1 !== exp_ovr ||
          busy !== (q0.size() != 0) || b1 !== (q0.size() != 0)) begin
        errors++;
        $display("FAIL mon_status t=%0t: overrun %b/%b busy %b/%b expected overrun %b busy %b",
                 $time, overrun, o1, busy, b1, exp_ovr, (q0.size() != 0));
      end
`ifdef AES_UNLOAD_DROPCNT_EN
      checks++;
      if (drop_cnt !== 8'(exp_drop) || dc1 !== 8'(exp_drop)) begin
        errors++;
        $display("FAIL mon_drop_cnt t=%0t: got %0d/%0d expected %0d", $time, drop_cnt, dc1, exp_drop);
      end
`endif
      start_wait = 1'b0;
      hs   = ev && (m_ready === 1'b1);
      last = hs && (q0.size() % 4 == 1);
      pend = (q0.size() + 3) / 4;
      if (hs) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (done === 1'b1) begin
        if (pend < 2 || last) begin
          if (q0.size() == 0 && !last) start_wait = 1'b1;
          for (int k = 0; k < 4; k++) begin
            q0.push_back(wd(text_out, k, 1'b1));
            q1.push_back(wd(text_out, k, 1'b0));
          end
        end else begin
          exp_ovr = 1'b1;
          if (exp_drop < 255) exp_drop++;
        end
      end
    end
  end

  // Observation buffers shared by the collecting tasks.
  logic [31:0] got0 [16];
  logic [31:0] got1 [16];
  logic        gotl [16];
  int          n_got, first_cyc, last_cyc;
  logic        busy_after;

  task automatic pulse_done(input logic [127:0] b);
    done = 1'b1;
    text_out = b;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic collect(input int nwords, input int max_cyc);
    n_got = 0; first_cyc = -1; last_cyc = -1; busy_after = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (n_got == nwords && cyc == last_cyc + 1) busy_after = busy;
      if (m_valid && m_ready && n_got < nwords) begin
        got0[n_got] = m_data;
        got1[n_got] = d1;
        gotl[n_got] = m_last;
        if (n_got == 0) first_cyc = cyc;
        n_got++;
        if (n_got == nwords) last_cyc = cyc;
      end
      @(posedge clk); #1;
      if (n_got == nwords && cyc > last_cyc) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid %b data %h last %b overrun %b busy %b, expected all 0",
               m_valid, m_data, m_last, overrun, busy);
    end
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    pulse_done(BLK1);
    collect(4, 12);
    checks++;
    if (n_got != 4 || first_cyc != 1 || last_cyc != 4) begin
      errors++;
      $display("FAIL single_timing: words %0d first %0d last %0d, expected 4 words at cycles 1..4",
               n_got, first_cyc, last_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0[k] !== wd(BLK1, k, 1'b1) || got1[k] !== wd(BLK1, 3 - k, 1'b1) || gotl[k] !== (k == 3)) begin
        errors++;
        $display("FAIL single_word%0d: msw %h lsw %h last %b, expected %h / %h last %b", k,
                 got0[k], got1[k], gotl[k], wd(BLK1, k, 1'b1), wd(BLK1, 3 - k, 1'b1), (k == 3));
      end
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: busy %b after last word, expected 0", busy_after);
    end
    wait_cycles(2);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit          held_valid;
    int          n;
    n = 0; held_valid = 1'b0; held = '0;
    m_ready = 1'b0;
    pulse_done(BLK1);
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      m_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (held_valid) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          errors++;
          $display("FAIL bp_stable: valid %b data %h, expected 1 %h", m_valid, m_data, held);
        end
      end
      held_valid = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          got0[n] = m_data;
          n++;
        end else begin
          held = m_data;
          held_valid = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_cycles(3);
    checks++;
    if (n != 4 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: handshakes %0d valid-after %b, expected 4 and 0", n, m_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0[k] !== wd(BLK1, k, 1'b1)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h expected %h", k, got0[k], wd(BLK1, k, 1'b1));
      end
    end
  endtask

  task automatic test_coincident();
    logic [127:0] blk [3];
    bit fired;
    int n;
    for (int i = 0; i < 3; i++) blk[i] = rand_blk();
    fired = 1'b0; n = 0;
    m_ready = 1'b0;
    pulse_done(blk[0]);
    pulse_done(blk[1]);
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 12; cyc++) begin
      if (!fired && m_last) begin
        done = 1'b1;
        text_out = blk[2];
        fired = 1'b1;
      end
      @(negedge clk);
      if (m_valid && m_ready) begin
        got0[n] = m_data;
        n++;
      end
      @(posedge clk); #1;
      done = 1'b0;
    end
    checks++;
    if (!fired || n != 12 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL coincident: fired %b words %0d overrun %b, expected 1 12 0", fired, n, overrun);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (got0[k] !== wd(blk[k / 4], k % 4, 1'b1)) begin
        errors++;
        $display("FAIL coincident_word%0d: got %h expected %h", k, got0[k], wd(blk[k / 4], k % 4, 1'b1));
      end
    end
    wait_cycles(2);
  endtask

  task automatic test_overrun();
    logic [127:0] blk [3];
    for (int i = 0; i < 3; i++) blk[i] = rand_blk();
    m_ready = 1'b0;
    pulse_done(blk[0]);
    pulse_done(blk[1]);
    pulse_done(blk[2]);
    wait_cycles(2);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1 || m_valid !== 1'b1 || m_data !== wd(blk[0], 0, 1'b1)) begin
      errors++;
      $display("FAIL overrun_flag: overrun %b busy %b valid %b data %h, expected 1 1 1 %h",
               overrun, busy, m_valid, m_data, wd(blk[0], 0, 1'b1));
    end
`ifdef AES_UNLOAD_DROPCNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL overrun_drop_cnt: got %0d expected 1", drop_cnt);
    end
`endif
    m_ready = 1'b1;
    collect(8, 20);
    checks++;
    if (n_got != 8 || last_cyc - first_cyc != 7 || busy_after !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drain: words %0d span %0d busy %b overrun %b, expected 8 7 0 1",
               n_got, last_cyc - first_cyc, busy_after, overrun);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got0[k] !== wd(blk[k / 4], k % 4, 1'b1)) begin
        errors++;
        $display("FAIL overrun_word%0d: got %h expected %h", k, got0[k], wd(blk[k / 4], k % 4, 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] x, y;
    int  n;
    bit  hit, saw_last;
    x = rand_blk(); y = rand_blk();
    n = 0; hit = 1'b0; saw_last = 1'b0;
    m_ready = 1'b1;
    pulse_done(x);
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        n++;
        if (m_last) saw_last = 1'b1;
      end
      @(posedge clk); #1;
      if (n == 2) hit = 1'b1;
    end
    checks++;
    if (!hit || saw_last || m_valid !== 1'b1 || m_data !== wd(x, 2, 1'b1)) begin
      errors++;
      $display("FAIL rstmid_pre: reached %b last %b valid %b data %h, expected 1 0 1 %h",
               hit, saw_last, m_valid, m_data, wd(x, 2, 1'b1));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid %b data %h last %b overrun %b busy %b, expected all 0",
               m_valid, m_data, m_last, overrun, busy);
    end
    @(posedge clk); #1;
    pulse_done(rand_blk());
    rst = 1'b0;
    wait_cycles(2);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done_ignored: busy %b valid %b, expected 0 0", busy, m_valid);
    end
    pulse_done(y);
    collect(4, 12);
    checks++;
    if (n_got != 4 || got0[0] !== wd(y, 0, 1'b1) || got0[3] !== wd(y, 3, 1'b1) ||
        gotl[2] !== 1'b0 || gotl[3] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_restart: words %0d first %h last %h, expected 4 %h %h",
               n_got, got0[0], got0[3], wd(y, 0, 1'b1), wd(y, 3, 1'b1));
    end
  endtask

  task automatic test_random();
    int gap;
    gap = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (gap == 0) begin
        done = 1'b1;
        text_out = rand_blk();
        gap = $urandom_range(1, 7);
      end else begin
        done = 1'b0;
        gap--;
      end
      @(posedge clk); #1;
    end
    done = 1'b0;
    m_ready = 1'b1;
    wait_cycles(20);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: busy %b valid %b, expected 0 0", busy, m_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_coincident();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
